// File: rtl/enc_quad_decoder.sv
// Rotary-encoder Pmod front-end: per-pin synchroniser/debounce lanes feeding a
// detent-resolution quadrature decoder with a wrapping position counter.
`timescale 1ns/1ps

module enc_deb_lane #(
  parameter int unsigned DEB_CYCLES = 5000,
  parameter logic        RST_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o
);
  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [1:0]       sync_q;
  logic             deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced pin disagrees with the debounced value;
  // any agreement (including a glitch returning) restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) deb_d = sync_q[1];
      else                                 cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RST_VAL}};
      deb_q  <= RST_VAL;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level_o = deb_q;
endmodule

module enc_quad_decoder #(
  parameter int unsigned DEB_CYCLES = 5000,
  parameter int unsigned POS_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             enc_btn,
  input  logic             enc_sw,
  output logic [POS_W-1:0] position,
  output logic             step_valid,
  output logic             step_dir,
  output logic             btn_press,
  output logic             btn_level,
  output logic             sw_level,
  output logic             quad_err
);
  // Lane order: A, B, button, switch. A/B idle high so release sits at detent 11.
  localparam int unsigned        NUM_LANES = 4;
  localparam logic [NUM_LANES-1:0] LANE_RST = 4'b0011;

  logic [NUM_LANES-1:0] raw, deb;
  assign raw = {enc_sw, enc_btn, enc_b, enc_a};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    enc_deb_lane #(
      .DEB_CYCLES (DEB_CYCLES),
      .RST_VAL    (LANE_RST[g])
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (raw[g]),
      .level_o (deb[g])
    );
  end

  // Phase index along the CW order 11 -> 01 -> 00 -> 10; differences mod 4
  // give +1 (CW), 3 (CCW) or 2 (both bits flipped).
  function automatic logic [1:0] phase(input logic [1:0] ab);
    case (ab)
      2'b11:   phase = 2'd0;
      2'b01:   phase = 2'd1;
      2'b00:   phase = 2'd2;
      default: phase = 2'd3;
    endcase
  endfunction

  logic [1:0]        ab_cur, ab_q;
  logic [1:0]        diff;
  logic signed [3:0] q_q, q_d, q_sum;
  logic              step_d, cw_d, err_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              step_q, dir_q, dir_d, err_q;
  logic              btn_prev_q, press_q, press_d;

  assign ab_cur = {deb[0], deb[1]};
  assign diff   = phase(ab_cur) - phase(ab_q);

  always_comb begin
    q_sum = q_q;
    case (diff)
      2'd1:    if (q_q != 4'sd4)  q_sum = q_q + 4'sd1;
      2'd3:    if (q_q != -4'sd4) q_sum = q_q - 4'sd1;
      default: ;
    endcase

    q_d    = q_q;
    step_d = 1'b0;
    cw_d   = 1'b0;
    err_d  = 1'b0;
    if (!ena) begin
      q_d = '0;
    end else if (ab_cur != ab_q) begin
      if (diff == 2'd2) begin
        err_d = 1'b1;
        q_d   = '0;
      end else if (ab_cur == 2'b11) begin
        // Only a full, uninterrupted quarter-step count in one direction steps.
        q_d = '0;
        if (q_sum == 4'sd4) begin
          step_d = 1'b1;
          cw_d   = 1'b1;
        end else if (q_sum == -4'sd4) begin
          step_d = 1'b1;
        end
      end else begin
        q_d = q_sum;
      end
    end
  end

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (step_d) begin
      pos_d = cw_d ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      dir_d = cw_d;
    end
  end

  assign press_d = ena & deb[2] & ~btn_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ab_q       <= 2'b11;
      q_q        <= '0;
      pos_q      <= '0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      err_q      <= 1'b0;
      btn_prev_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      ab_q       <= ab_cur;
      q_q        <= q_d;
      pos_q      <= pos_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      err_q      <= err_d;
      btn_prev_q <= deb[2];
      press_q    <= press_d;
    end
  end

  assign position   = pos_q;
  assign step_valid = step_q;
  assign step_dir   = dir_q;
  assign quad_err   = err_q;
  assign btn_press  = press_q;
  assign btn_level  = deb[2];
  assign sw_level   = deb[3];
endmodule

// File: tb/tb_enc_quad_decoder.sv
// Randomised bench for enc_quad_decoder: detent-level reference model plus
// pulse counters sampled on the falling clock edge.
`timescale 1ns/1ps

module tb_enc_quad_decoder;
  localparam int DEB = 4;
  localparam int PW  = 4;

  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
  logic enc_a = 1'b1, enc_b = 1'b1, enc_btn = 1'b0, enc_sw = 1'b0;
  logic [PW-1:0] position;
  logic step_valid, step_dir, btn_press, btn_level, sw_level, quad_err;

  always #5 clk = ~clk;

  enc_quad_decoder #(.DEB_CYCLES(DEB), .POS_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .enc_a(enc_a), .enc_b(enc_b), .enc_btn(enc_btn), .enc_sw(enc_sw),
    .position(position), .step_valid(step_valid), .step_dir(step_dir),
    .btn_press(btn_press), .btn_level(btn_level), .sw_level(sw_level),
    .quad_err(quad_err)
  );

  int n_tests = 0, n_fail = 0;
  int n_step = 0, n_err = 0, n_press = 0;

  // Count every high cycle, so a pulse longer than one cycle shows up as extra.
  always @(negedge clk) begin
    if (step_valid) n_step++;
    if (quad_err)   n_err++;
    if (btn_press)  n_press++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: phase index along CW order 11,01,00,10.
  logic [1:0] AB_OF [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
  int m_ph = 0, m_q = 0, m_pos = 0, m_dir = 0;
  int e_step = 0, e_err = 0, e_press = 0;
  bit m_ena = 1'b0;

  task automatic model_move(input int np);
    int d;
    d = (np - m_ph + 4) % 4;
    if (d != 0) begin
      if (!m_ena) m_q = 0;
      else if (d == 2) begin
        e_err++;
        m_q = 0;
      end else begin
        m_q += (d == 1) ? 1 : -1;
        if (m_q > 4)  m_q = 4;
        if (m_q < -4) m_q = -4;
        if (np == 0) begin
          if (m_q == 4) begin
            m_pos = (m_pos + 1) % 16; m_dir = 1; e_step++;
          end else if (m_q == -4) begin
            m_pos = (m_pos + 15) % 16; m_dir = 0; e_step++;
          end
          m_q = 0;
        end
      end
    end
    m_ph = np;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic go(input int np, input int hold);
    model_move(np);
    {enc_a, enc_b} = AB_OF[np];
    cyc(hold);
  endtask

  task automatic detent(input bit cw);
    for (int i = 0; i < 4; i++) go((m_ph + (cw ? 1 : 3)) % 4, $urandom_range(8, 12));
  endtask

  task automatic glitch();
    enc_a = ~enc_a;
    cyc($urandom_range(1, DEB - 1));
    enc_a = ~enc_a;
    cyc(8);
  endtask

  task automatic press();
    enc_btn = 1'b1;
    cyc(10);
    chk("btn_hi", btn_level, 1);
    enc_btn = 1'b0;
    cyc(10);
    if (m_ena) e_press++;
  endtask

  task automatic set_ena(input bit e);
    ena = e;
    m_ena = e;
    if (!e) m_q = 0;
  endtask

  task automatic settle_check(input string tag);
    cyc(10);
    chk({tag, ":pos"},   position, m_pos);
    chk({tag, ":dir"},   step_dir, m_dir);
    chk({tag, ":steps"}, n_step, e_step);
    chk({tag, ":errs"},  n_err, e_err);
    chk({tag, ":press"}, n_press, e_press);
    chk({tag, ":btn"},   btn_level, enc_btn);
    chk({tag, ":sw"},    sw_level, enc_sw);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(3);
    chk("rst_pos", position, 0);
    chk("rst_step", step_valid, 0);
    chk("rst_err", quad_err, 0);
    chk("rst_btn", btn_level, 0);
    rst_n = 1'b1;
    set_ena(1'b1);
    cyc(50);
    chk("idle_pos", position, 0);
    chk("idle_steps", n_step, 0);
    chk("idle_errs", n_err, 0);

    // Debounce latency boundary on the button
    enc_btn = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("btn_lat5", btn_level, 0);
    @(posedge clk); #1;
    chk("btn_lat6", btn_level, 1);
    cyc(4);
    enc_btn = 1'b0;
    cyc(10);
    e_press++;
    settle_check("btn1");

    detent(1'b1);
    settle_check("cw1");
    chk("cw1_abs", position, 1);
    for (int i = 0; i < 15; i++) detent(1'b1);
    settle_check("wrap");
    chk("wrap_abs", position, 0);
    detent(1'b0);
    settle_check("ccw");
    chk("ccw_abs", position, 15);

    glitch();
    settle_check("glitch");
    go(1, 10); go(0, 10);
    settle_check("partial");
    chk("partial_abs", position, 15);

    go(2, 10);
    settle_check("illegal");
    go(3, 10); go(0, 10);
    detent(1'b1);
    settle_check("after_err");
    chk("after_err_abs", position, 0);

    set_ena(1'b0);
    detent(1'b1);
    press();
    go(1, 10); go(2, 10);
    set_ena(1'b1);
    go(3, 10); go(0, 10);
    settle_check("ena_off");
    chk("ena_off_abs", position, 0);
    detent(1'b1);
    detent(1'b1);
    settle_check("ena_on");

    // Asynchronous reset in the middle of a rotation
    go(1, 10); go(2, 10);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_pos", position, 0);
    chk("mid_rst_dir", step_dir, 0);
    chk("mid_rst_step", step_valid, 0);
    {enc_a, enc_b} = 2'b11;
    m_ph = 0; m_q = 0; m_pos = 0; m_dir = 0;
    cyc(5);
    rst_n = 1'b1;
    cyc(20);
    settle_check("post_rst");

    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 11))
        0, 1, 2, 3: detent(1'b1);
        4, 5:       detent(1'b0);
        6, 7:       go((m_ph + (($urandom_range(0, 1) == 1) ? 1 : 3)) % 4, $urandom_range(8, 12));
        8:          go((m_ph + 2) % 4, $urandom_range(8, 12));
        9:          glitch();
        10:         press();
        default: begin
          set_ena($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 1) == 1) enc_sw = ~enc_sw;
        end
      endcase
      settle_check("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
